// File: rtl/mm_tile_sequencer.sv
// Tile-loop address sequencer for a systolic matrix-multiply array: walks k, then B column tile, then A row tile.
module mm_tile_sequencer #(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int P  = 4,
  parameter int N1 = 4,
  parameter int N2 = 4,
  localparam int AW_A = ($clog2(M*K/N1) > 1) ? $clog2(M*K/N1) : 1,
  localparam int AW_B = ($clog2(P*K/N2) > 1) ? $clog2(P*K/N2) : 1,
  localparam int KW   = ($clog2(K) > 1) ? $clog2(K) : 1,
  localparam int RW   = ($clog2(M/N1) > 1) ? $clog2(M/N1) : 1,
  localparam int CW   = ($clog2(P/N2) > 1) ? $clog2(P/N2) : 1
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW_A-1:0] rd_addr_A,
  output logic [AW_B-1:0] rd_addr_B,
  output logic [KW-1:0]   k_cntr,
  output logic [RW-1:0]   row_tile,
  output logic [CW-1:0]   col_tile,
  output logic            tile_first,
  output logic            tile_last,
  output logic            row_adv
);

  localparam int FW = ($clog2(N1+N2) > 1) ? $clog2(N1+N2) : 1;

  localparam logic [KW-1:0]   K_LAST  = KW'(K-1);
  localparam logic [RW-1:0]   R_LAST  = RW'(M/N1-1);
  localparam logic [CW-1:0]   C_LAST  = CW'(P/N2-1);
  localparam logic [FW-1:0]   F_LAST  = FW'(N1+N2-1);
  localparam logic [AW_A-1:0] K_A     = AW_A'(K);
  localparam logic [AW_B-1:0] K_B     = AW_B'(K);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic            k_last, c_last, r_last;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fl_q    <= fl_d;
    end
  end

  assign k_last = (k_q == K_LAST);
  assign c_last = (col_q == C_LAST);
  assign r_last = (row_q == R_LAST);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    fl_d    = fl_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (k_last) begin
            k_d = '0;
            if (c_last) begin
              col_d = '0;
              if (r_last) begin
                row_d   = '0;
                state_d = FLUSH;
                fl_d    = '0;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      FLUSH: begin
        if (fl_q == F_LAST) state_d = DONE;
        else                fl_d    = fl_q + FW'(1);
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
        row_d   = '0;
        col_d   = '0;
        fl_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN) || (state_q == FLUSH);
  assign done       = (state_q == DONE);
  assign rd_en      = (state_q == RUN) && !stall;
  assign tile_first = rd_en && (k_q == '0);
  assign tile_last  = rd_en && k_last;
  assign row_adv    = tile_last && c_last;
  assign k_cntr     = k_q;
  assign row_tile   = row_q;
  assign col_tile   = col_q;
  assign rd_addr_A  = AW_A'(row_q) * K_A + AW_A'(k_q);
  assign rd_addr_B  = AW_B'(col_q) * K_B + AW_B'(k_q);

endmodule

// File: tb/tb_mm_tile_sequencer.sv
module tb_mm_tile_sequencer;

  localparam int AM = 4, AK = 4, AP = 4, AN1 = 2, AN2 = 2;
  localparam int BM = 8, BK = 1, BP = 4, BN1 = 4, BN2 = 2;

  logic fclk = 1'b0;
  always #5 fclk = ~fclk;

  logic       rst_a = 1'b1, start_a = 1'b0, stall_a = 1'b0;
  logic       busy_a, done_a, rd_en_a, tf_a, tl_a, ra_a;
  logic [2:0] addr_a_a, addr_b_a;
  logic [1:0] k_a;
  logic [0:0] row_a, col_a;

  logic       rst_b = 1'b1, start_b = 1'b0, stall_b = 1'b0;
  logic       busy_b, done_b, rd_en_b, tf_b, tl_b, ra_b;
  logic [0:0] addr_a_b, addr_b_b, k_b, row_b, col_b;

  mm_tile_sequencer #(.M(AM), .K(AK), .P(AP), .N1(AN1), .N2(AN2)) dut_a (
    .fclk(fclk), .rst(rst_a), .start(start_a), .stall(stall_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
    .rd_addr_A(addr_a_a), .rd_addr_B(addr_b_a), .k_cntr(k_a),
    .row_tile(row_a), .col_tile(col_a),
    .tile_first(tf_a), .tile_last(tl_a), .row_adv(ra_a)
  );

  mm_tile_sequencer #(.M(BM), .K(BK), .P(BP), .N1(BN1), .N2(BN2)) dut_b (
    .fclk(fclk), .rst(rst_b), .start(start_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr_A(addr_a_b), .rd_addr_B(addr_b_b), .k_cntr(k_b),
    .row_tile(row_b), .col_tile(col_b),
    .tile_first(tf_b), .tile_last(tl_b), .row_adv(ra_b)
  );

  // Model: a run is just a beat index 0..total-1; everything else is derived arithmetically.
  typedef struct packed { int mode; int beat; int fl; } mdl_t;  // mode 0 idle,1 run,2 flush,3 done

  mdl_t ma = '0, mb = '0;
  int   n_checks = 0, n_err = 0;
  int   gcyc = 0, t0 = 0;
  bit   chk_en = 1'b0;
  logic [87:0] hist_a [64];
  logic [87:0] hist_b [64];

  function automatic mdl_t step(mdl_t m, logic r, logic s, logic st, int total, int nfl);
    mdl_t n = m;
    if (r) begin
      n.mode = 0; n.beat = 0; n.fl = 0;
    end else begin
      case (m.mode)
        0: if (s) begin n.mode = 1; n.beat = 0; end
        1: if (!st) begin
             n.beat = m.beat + 1;
             if (n.beat == total) begin n.mode = 2; n.fl = 0; n.beat = 0; end
           end
        2: if (m.fl == nfl - 1) n.mode = 3; else n.fl = m.fl + 1;
        default: begin n.mode = 0; n.beat = 0; n.fl = 0; end
      endcase
    end
    return n;
  endfunction

  // Field order: busy, done, rd_en, tile_first, tile_last, row_adv, addrA, addrB, k, row, col
  function automatic logic [87:0] expect_vec(mdl_t m, logic st, int kk, int ct);
    int k = 0, col = 0, row = 0;
    logic run, re, tl;
    run = (m.mode == 1);
    re  = run && !st;
    if (run) begin
      k   = m.beat % kk;
      col = (m.beat / kk) % ct;
      row = m.beat / (kk * ct);
    end
    tl = re && (k == kk - 1);
    return {8'(run || m.mode == 2), 8'(m.mode == 3), 8'(re), 8'(re && k == 0), 8'(tl),
            8'(tl && col == ct - 1), 8'(row * kk + k), 8'(col * kk + k), 8'(k), 8'(row), 8'(col)};
  endfunction

  function automatic logic [87:0] vec_a();
    return {8'(busy_a), 8'(done_a), 8'(rd_en_a), 8'(tf_a), 8'(tl_a), 8'(ra_a),
            8'(addr_a_a), 8'(addr_b_a), 8'(k_a), 8'(row_a), 8'(col_a)};
  endfunction

  function automatic logic [87:0] vec_b();
    return {8'(busy_b), 8'(done_b), 8'(rd_en_b), 8'(tf_b), 8'(tl_b), 8'(ra_b),
            8'(addr_a_b), 8'(addr_b_b), 8'(k_b), 8'(row_b), 8'(col_b)};
  endfunction

  function automatic int fld(logic [87:0] v, int f);
    return int'(v[87 - 8*f -: 8]);
  endfunction

  function automatic logic [87:0] hget(int inst, int i);
    return (inst == 0) ? hist_a[i] : hist_b[i];
  endfunction

  function automatic int cnt(int inst, int f, int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (fld(hget(inst, i), f) != 0) c++;
    return c;
  endfunction

  function automatic int first(int inst, int f, int n);
    for (int i = 0; i < n; i++) if (fld(hget(inst, i), f) != 0) return i;
    return -1;
  endfunction

  function automatic int last(int inst, int f, int n);
    int l = -1;
    for (int i = 0; i < n; i++) if (fld(hget(inst, i), f) != 0) l = i;
    return l;
  endfunction

  task automatic check(string name, logic [87:0] got, logic [87:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  always @(posedge fclk) begin
    gcyc <= gcyc + 1;
    ma   <= step(ma, rst_a, start_a, stall_a, (AM/AN1)*(AP/AN2)*AK, AN1 + AN2);
    mb   <= step(mb, rst_b, start_b, stall_b, (BM/BN1)*(BP/BN2)*BK, BN1 + BN2);
  end

  always @(negedge fclk) begin
    logic [87:0] ga, gb;
    int tc;
    ga = vec_a();
    gb = vec_b();
    tc = gcyc - t0;
    if (tc >= 0 && tc < 64) begin
      hist_a[tc] = ga;
      hist_b[tc] = gb;
    end
    if (chk_en) begin
      check("model_a", ga, expect_vec(ma, stall_a, AK, AP/AN2));
      check("model_b", gb, expect_vec(mb, stall_b, BK, BP/BN2));
    end
  end

  // Cycle i of the scenario is the cycle in which start is first driven (i = 0).
  task automatic run(int inst, int n, int hold_to, int pulse2, int s0, int s1, int rst_at);
    @(posedge fclk); #1;
    t0 = gcyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge fclk); #1; end
      if (inst == 0) begin
        start_a = (i <= hold_to) || (i == pulse2);
        stall_a = (i >= s0) && (i <= s1);
        rst_a   = (i == rst_at);
      end else begin
        start_b = (i <= hold_to) || (i == pulse2);
        stall_b = (i >= s0) && (i <= s1);
        rst_b   = (i == rst_at);
      end
    end
    @(posedge fclk); #1;
    start_a = 0; stall_a = 0; rst_a = 0;
    start_b = 0; stall_b = 0; rst_b = 0;
  endtask

  initial begin
    repeat (2) @(posedge fclk);
    #1;
    rst_a = 0; rst_b = 0;
    chk_en = 1'b1;
    @(negedge fclk);
    check("reset_a", vec_a(), 88'h0);
    check("reset_b", vec_b(), 88'h0);

    // Plain run
    run(0, 30, 0, -1, -1, -1, -1);
    check_int("done_cycle", first(0, 1, 30), 21);
    check_int("done_count", cnt(0, 1, 30), 1);
    check_int("rd_en_count", cnt(0, 2, 30), 16);
    check_int("rd_en_first", first(0, 2, 30), 1);
    check_int("rd_en_last", last(0, 2, 30), 16);
    check_int("busy_count", cnt(0, 0, 30), 20);
    check_int("busy_last", last(0, 0, 30), 20);
    check_int("row_adv_count", cnt(0, 5, 30), 2);
    check_int("row_adv_first", first(0, 5, 30), 8);
    check_int("row_adv_last", last(0, 5, 30), 16);
    check_int("tile_first_count", cnt(0, 3, 30), 4);
    check_int("tile_first_c5", fld(hist_a[5], 3), 1);
    check_int("tile_first_c9", fld(hist_a[9], 3), 1);
    check_int("tile_first_c13", fld(hist_a[13], 3), 1);
    check_int("addrA_c5", fld(hist_a[5], 6), 0);
    check_int("addrB_c5", fld(hist_a[5], 7), 4);
    check_int("addrA_c9", fld(hist_a[9], 6), 4);
    check_int("addrB_c9", fld(hist_a[9], 7), 0);

    // Stall cycles 3-5
    run(0, 30, 0, -1, 3, 5, -1);
    check_int("stall_done_cycle", first(0, 1, 30), 24);
    check_int("stall_rd_count", cnt(0, 2, 30), 16);
    check_int("stall_rd_c4", fld(hist_a[4], 2), 0);
    check_int("stall_k_c3", fld(hist_a[3], 8), 2);
    check_int("stall_k_c5", fld(hist_a[5], 8), 2);
    check_int("stall_addrA_c5", fld(hist_a[5], 6), 2);

    // Reset mid-run, then a fresh run
    run(0, 15, 0, -1, -1, -1, 10);
    check("reset_midrun_c11", hist_a[11], 88'h0);
    check_int("reset_midrun_done", cnt(0, 1, 15), 0);
    run(0, 30, 0, -1, -1, -1, -1);
    check_int("rerun_done_cycle", first(0, 1, 30), 21);
    check_int("rerun_rd_count", cnt(0, 2, 30), 16);

    // Reset wins over start
    run(0, 5, 0, -1, -1, -1, 0);
    check_int("rst_over_start_busy", cnt(0, 0, 5), 0);

    // Start held through busy and DONE: no second run
    run(0, 30, 21, -1, -1, -1, -1);
    check_int("held_start_done", cnt(0, 1, 30), 1);
    check_int("held_start_busy", cnt(0, 0, 30), 20);

    // Pulse right after done begins a new run
    run(0, 48, 20, 22, -1, -1, -1);
    check_int("restart_done_count", cnt(0, 1, 48), 2);
    check_int("restart_done_last", last(0, 1, 48), 43);
    check_int("restart_busy", cnt(0, 0, 48), 40);

    // K=1 configuration
    run(1, 15, 0, -1, -1, -1, -1);
    check_int("k1_beats", cnt(1, 2, 15), 4);
    check_int("k1_tile_first", cnt(1, 3, 15), 4);
    check_int("k1_tile_last", cnt(1, 4, 15), 4);
    check_int("k1_row_adv_count", cnt(1, 5, 15), 2);
    check_int("k1_row_adv_first", first(1, 5, 15), 2);
    check_int("k1_row_adv_last", last(1, 5, 15), 4);
    check_int("k1_done_cycle", first(1, 1, 15), 11);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge fclk); #1;
      rst_a   = ($urandom_range(0, 39) == 0);
      start_a = ($urandom_range(0, 5) == 0);
      stall_a = ($urandom_range(0, 3) == 0);
      rst_b   = ($urandom_range(0, 39) == 0);
      start_b = ($urandom_range(0, 5) == 0);
      stall_b = ($urandom_range(0, 3) == 0);
    end
    @(posedge fclk); #1;
    rst_a = 0; start_a = 0; stall_a = 0;
    rst_b = 0; start_b = 0; stall_b = 0;
    @(negedge fclk);
    @(negedge fclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
